execute_stage: RTL and testbench
================================

# execute_stage

Datapath execute stage for the 16-bit RISC core. It sits between the register-file read port and the write-back stage: it captures operands into A/B registers, shifts B, and runs the ALU. The result is held in register C, which drives the write-back stage's C input, and condition flags are held in a status register. An optional iterative multiplier adds a multi-cycle operation with a start/busy/done handshake.

## Interface
- WIDTH, 16, datapath width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- readdata  in  WIDTH  operand from register-file read port
- sximm5  in  WIDTH  sign-extended immediate
- loada, loadb  in  1  capture readdata into A / B
- asel  in  1  1: Ain=0, 0: Ain=A
- bsel  in  1  1: Bin=sximm5, 0: Bin=shifted B
- shift  in  2  00 none, 01 left 1, 10 logical right 1, 11 arithmetic right 1
- ALUop  in  2  00 add, 01 sub, 10 and, 11 not Bin
- loadc, loads  in  1  capture ALU result into C / flags into status
- start  in  1  multiply request (single-cycle pulse)
- C  out  WIDTH  result register, to write-back
- status  out  3  {V,N,Z}
- busy, done  out  1  multiply handshake

## Operation
- A, B: load on the clock edge when loada/loadb=1, otherwise hold.
- ALU is combinational on Ain/Bin. All arithmetic is mod 2^WIDTH.
- Z: result==0. N: result[WIDTH-1].
- V: signed overflow for add/sub; 0 for and/not.
- loadc: C<=ALU result. loads: status<=flags. Each is independent of the other.
- Multiply FSM: IDLE -> RUN (exactly WIDTH cycles, shift-add of Ain*Bin, low WIDTH bits kept) -> FIN (1 cycle) -> IDLE.
- start is accepted only in IDLE. Ain/Bin are latched into internal operand registers on the accept edge.
- At the edge leaving the last RUN cycle: C<=product, status<={0,N,Z} of the product.
- busy=1 throughout RUN. done=1 only in FIN.
- During RUN and FIN:
  - loadc and loads are ignored.
  - loada/loadb still act, but do not affect the product in flight.
  - start is ignored.
- Simultaneous loadc and accepted start in IDLE: C takes the ALU result now, and is overwritten by the product later.

## Timing
- Reset values: A=B=C=0, status=000, FSM=IDLE, busy=0, done=0.
- Reset asserted mid-multiply aborts the operation: all registers go to reset values and no done pulse is produced.
- loada/loadb/loadc/loads: result visible the cycle after the enabling edge.
- Operand path: A/B load (cycle n) -> loadc (cycle n+1) -> C valid at n+2.
- Multiply: start sampled at edge k.
  - busy high in cycles k+1..k+WIDTH.
  - done high and C valid in cycle k+WIDTH+1.
  - Next start accepted at edge k+WIDTH+2.
- No combinational path from any input to busy, done, C or status.

## Configuration
- EXEC_MUL_EN defined: multiplier FSM present, behaviour as above.
- EXEC_MUL_EN undefined:
  - start is ignored; busy and done tie to 0.
  - No FSM or operand registers are generated.
  - All other behaviour is identical.

## Structure
- risc_pkg holds:
  - WIDTH
  - ALUop encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_NOT)
  - shift encodings
  - multiplier state enum (ST_IDLE, ST_RUN, ST_FIN)
- One sub-module, exec_mul: contains the iterative multiplier with its FSM, counter and accumulator. It is instantiated only under EXEC_MUL_EN.
- Shifter and ALU stay inline as combinational logic.

## Test plan
- Reset, then idle: C=0x0000, status=000, busy=0, done=0.
- A=0x7FFF, B=0x0001, ALUop add, loadc+loads -> C=0x8000, status V=1,N=1,Z=0.
- A=0x0005, B=0x000A, shift=01, ALUop sub, loads -> C=0xFFF1, N=1, Z=0, V=0. Then B=0x8000, shift=11, bsel=0, asel=1, ALUop add -> C=0xC000.
- Multiply with EXEC_MUL_EN, A=0x0012, B=0x0034, start:
  - busy exactly 16 cycles, then done 1 cycle.
  - C=0x03A8, status=000.
  - A start pulse during busy is ignored.
- Reset asserted at RUN cycle 8 -> next cycle busy=0, C=0x0000, no done pulse. Then a fresh start completes normally.
- Without EXEC_MUL_EN: pulse start -> busy and done stay 0, C unchanged.

Source files
------------

// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared widths, ALU/shift encodings and multiplier states for the RISC datapath
package risc_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } mul_state_t;

endpackage

// File: rtl/exec_mul.sv
// rtl/exec_mul.sv - iterative shift-add multiplier (WIDTH steps, low WIDTH bits kept) with start/busy/done
module exec_mul
  import risc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             prod_valid,
  output logic [WIDTH-1:0] product
);

  mul_state_t       state_q, state_d;
  logic             accept;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    prod_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt_q == CNT_LAST) begin
          prod_valid = 1'b1;
          state_d    = ST_FIN;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // product is the accumulator after the current step, so on the last RUN
  // cycle it is already the full result and can be written straight to C
  assign product = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (accept) begin
      cnt_q    <= '0;
      mcand_q  <= ain;
      mplier_q <= bin;
      acc_q    <= '0;
    end else if (busy) begin
      cnt_q    <= cnt_q + 1'b1;
      mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      acc_q    <= product;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - A/B operand regs, B shifter, ALU, C and status regs; multiplier under EXEC_MUL_EN
module execute_stage
  import risc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] sximm5,
  input  logic             loada,
  input  logic             loadb,
  input  logic             asel,
  input  logic             bsel,
  input  logic [1:0]       shift,
  input  logic [1:0]       ALUop,
  input  logic             loadc,
  input  logic             loads,
  input  logic             start,
  output logic [WIDTH-1:0] C,
  output logic [2:0]       status,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] a_q, b_q, b_shifted, ain, bin, alu_out;
  logic             alu_v;
  logic [2:0]       alu_flags;
  logic             mul_active, mul_prod_valid;
  logic [WIDTH-1:0] mul_product;

  always_comb begin
    b_shifted = b_q;
    case (shift)
      SH_NONE: b_shifted = b_q;
      SH_LSL:  b_shifted = {b_q[WIDTH-2:0], 1'b0};
      SH_LSR:  b_shifted = {1'b0, b_q[WIDTH-1:1]};
      SH_ASR:  b_shifted = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: b_shifted = b_q;
    endcase
  end

  assign ain = asel ? '0 : a_q;
  assign bin = bsel ? sximm5 : b_shifted;

  // overflow: operands (after negating B for sub) agree in sign but the result does not
  always_comb begin
    alu_out = '0;
    alu_v   = 1'b0;
    case (ALUop)
      ALU_ADD: begin
        alu_out = ain + bin;
        alu_v   = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_out = ain - bin;
        alu_v   = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_out[WIDTH-1] != ain[WIDTH-1]);
      end
      ALU_AND: alu_out = ain & bin;
      ALU_NOT: alu_out = ~bin;
      default: alu_out = '0;
    endcase
  end

  assign alu_flags = {alu_v, alu_out[WIDTH-1], (alu_out == '0)};

`ifdef EXEC_MUL_EN
  exec_mul u_exec_mul (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ain        (ain),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .prod_valid (mul_prod_valid),
    .product    (mul_product)
  );
  assign mul_active = busy | done;
`else
  logic unused_start;
  assign unused_start   = start;
  assign busy           = 1'b0;
  assign done           = 1'b0;
  assign mul_active     = 1'b0;
  assign mul_prod_valid = 1'b0;
  assign mul_product    = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      C      <= '0;
      status <= 3'b000;
    end else begin
      if (loada) a_q <= readdata;
      if (loadb) b_q <= readdata;
      if (mul_prod_valid) begin
        C      <= mul_product;
        status <= {1'b0, mul_product[WIDTH-1], (mul_product == '0)};
      end else if (!mul_active) begin
        if (loadc) C      <= alu_out;
        if (loads) status <= alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - table-driven and randomized checks of execute_stage against an arithmetic model
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] readdata, sximm5;
  logic        loada, loadb, asel, bsel, loadc, loads, start;
  logic [1:0]  shift, ALUop;
  logic [15:0] C;
  logic [2:0]  status;
  logic        busy, done;

  int vec_cnt = 0;
  int err_cnt = 0;

  execute_stage dut (
    .clk(clk), .reset(reset), .readdata(readdata), .sximm5(sximm5),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
    .shift(shift), .ALUop(ALUop), .loadc(loadc), .loads(loads),
    .start(start), .C(C), .status(status), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b, sx;
    logic        as, bs;
    logic [1:0]  sh, op;
    logic [15:0] exp_c;
    logic [2:0]  exp_s;
  } vec_t;

  localparam int NVEC = 40;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int to_signed(input int u);
    return (u >= 32768) ? u - 65536 : u;
  endfunction

  function automatic logic [15:0] shift_model(input logic [15:0] b, input logic [1:0] sh);
    int u;
    u = int'(b);
    case (sh)
      2'd0: return b;
      2'd1: return 16'((u * 2) % 65536);
      2'd2: return 16'(u / 2);
      default: return 16'(u / 2 + ((u >= 32768) ? 32768 : 0));
    endcase
  endfunction

  function automatic logic [18:0] alu_model(input logic [15:0] ain, input logic [15:0] bin,
                                            input logic [1:0] op);
    int ua, ub, r, res;
    bit v;
    ua = int'(ain);
    ub = int'(bin);
    v  = 1'b0;
    case (op)
      2'd0: begin
        r = to_signed(ua) + to_signed(ub);
        v = (r > 32767) || (r < -32768);
        res = (ua + ub) % 65536;
      end
      2'd1: begin
        r = to_signed(ua) - to_signed(ub);
        v = (r > 32767) || (r < -32768);
        res = (ua - ub + 65536) % 65536;
      end
      2'd2: res = int'(ain & bin);
      default: res = 65535 - ub;
    endcase
    return {v, (res >= 32768), (res == 0), 16'(res)};
  endfunction

  task automatic load_ab(input logic [15:0] a, input logic [15:0] b);
    readdata = a; loada = 1'b1;
    @(negedge clk);
    loada = 1'b0; readdata = b; loadb = 1'b1;
    @(negedge clk);
    loadb = 1'b0;
  endtask

  task automatic set_vec(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] sx, input logic as, input logic bs,
                         input logic [1:0] sh, input logic [1:0] op,
                         input logic [15:0] ec, input logic [2:0] es);
    vecs[i].a = a; vecs[i].b = b; vecs[i].sx = sx; vecs[i].as = as; vecs[i].bs = bs;
    vecs[i].sh = sh; vecs[i].op = op; vecs[i].exp_c = ec; vecs[i].exp_s = es;
  endtask

`ifdef EXEC_MUL_EN
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] sx,
                         input logic bs, input logic [1:0] sh, input bit poke);
    int busy_n, done_n;
    logic [15:0] binv, expp, alu_now;
    load_ab(a, b);
    asel = 1'b0; bsel = bs; shift = sh; sximm5 = sx; ALUop = 2'd0;
    binv    = bs ? sx : shift_model(b, sh);
    expp    = 16'((longint'(a) * longint'(binv)) % 65536);
    alu_now = 16'((int'(a) + int'(binv)) % 65536);
    start = 1'b1; loadc = 1'b1;
    @(negedge clk);
    start = 1'b0; loadc = 1'b0;
    check("mul_start_loadc_c", C, alu_now);
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 40 && done_n == 0; i++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        check("mul_product", C, expp);
        check("mul_status", status, {1'b0, expp[15], (expp == 16'h0)});
        asel = 1'b1; bsel = 1'b1; sximm5 = expp ^ 16'h5A5A;
        start = 1'b1; loadc = 1'b1; loads = 1'b1;
        @(negedge clk);
        start = 1'b0; loadc = 1'b0; loads = 1'b0;
        check("fin_loadc_ignored", C, expp);
        check("fin_start_ignored", busy, 1'b0);
        check("done_one_cycle", done, 1'b0);
      end else begin
        start = poke && (busy_n == 5);
        loadc = poke && (busy_n == 5);
        loada = poke && (busy_n == 6);
        readdata = 16'($urandom);
        @(negedge clk);
        start = 1'b0; loadc = 1'b0; loada = 1'b0;
      end
    end
    check("mul_busy_cycles", busy_n, 16);
    check("mul_done_seen", done_n, 1);
  endtask
`endif

  initial begin
    logic [18:0] m;
    logic [15:0] c_hold;
    int seen;
    reset = 1'b1; readdata = '0; sximm5 = '0; loada = 0; loadb = 0; asel = 0; bsel = 0;
    loadc = 0; loads = 0; start = 0; shift = 2'd0; ALUop = 2'd0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_c", C, 16'h0000);
    check("reset_status", status, 3'b000);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);

    set_vec(0, 16'h7FFF, 16'h0001, 16'h0, 0, 0, 2'd0, 2'd0, 16'h8000, 3'b110);
    set_vec(1, 16'h0005, 16'h000A, 16'h0, 0, 0, 2'd1, 2'd1, 16'hFFF1, 3'b010);
    set_vec(2, 16'h1234, 16'h8000, 16'h0, 1, 0, 2'd3, 2'd0, 16'hC000, 3'b010);
    set_vec(3, 16'h0005, 16'h0005, 16'h0, 0, 0, 2'd0, 2'd1, 16'h0000, 3'b001);
    set_vec(4, 16'h8000, 16'h0001, 16'h0, 0, 0, 2'd0, 2'd1, 16'h7FFF, 3'b100);
    set_vec(5, 16'h0000, 16'h8001, 16'h0, 0, 0, 2'd2, 2'd3, 16'hBFFF, 3'b010);
    set_vec(6, 16'hF0F0, 16'h0000, 16'hFF0F, 0, 1, 2'd0, 2'd2, 16'hF000, 3'b010);
    for (int i = 7; i < NVEC; i++) begin
      vecs[i].a  = 16'($urandom); vecs[i].b  = 16'($urandom); vecs[i].sx = 16'($urandom);
      vecs[i].as = 1'($urandom);  vecs[i].bs = 1'($urandom);
      vecs[i].sh = 2'($urandom);  vecs[i].op = 2'($urandom);
      m = alu_model(vecs[i].as ? 16'h0 : vecs[i].a,
                    vecs[i].bs ? vecs[i].sx : shift_model(vecs[i].b, vecs[i].sh), vecs[i].op);
      vecs[i].exp_c = m[15:0];
      vecs[i].exp_s = m[18:16];
    end

    for (int i = 0; i < NVEC; i++) begin
      load_ab(vecs[i].a, vecs[i].b);
      asel = vecs[i].as; bsel = vecs[i].bs; sximm5 = vecs[i].sx;
      shift = vecs[i].sh; ALUop = vecs[i].op; loadc = 1'b1; loads = 1'b1;
      @(negedge clk);
      loadc = 1'b0; loads = 1'b0;
      check($sformatf("vec%0d_c", i), C, vecs[i].exp_c);
      check($sformatf("vec%0d_status", i), status, vecs[i].exp_s);
    end

    // loadc and loads act independently
    load_ab(16'h0003, 16'h0003);
    asel = 0; bsel = 0; shift = 2'd0; ALUop = 2'd1; loadc = 1'b1;
    @(negedge clk);
    loadc = 1'b0;
    check("loadc_only_c", C, 16'h0000);
    check("loadc_only_status_held", status, vecs[NVEC-1].exp_s);
    ALUop = 2'd0; loads = 1'b1;
    @(negedge clk);
    loads = 1'b0;
    check("loads_only_c_held", C, 16'h0000);
    check("loads_only_status", status, 3'b000);

`ifdef EXEC_MUL_EN
    run_mul(16'h0012, 16'h0034, 16'h0, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 6; i++)
      run_mul(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 2'($urandom), 1'b0);
    run_mul(16'h0100, 16'h0100, 16'h0, 1'b0, 2'd0, 1'b0);

    // reset during RUN aborts without a done pulse
    load_ab(16'h0012, 16'h0034);
    asel = 0; bsel = 0; shift = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    check("abort_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_c", C, 16'h0000);
    check("abort_status", status, 3'b000);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    check("abort_no_done", seen, 0);
    run_mul(16'h0012, 16'h0034, 16'h0, 1'b0, 2'd0, 1'b0);
`else
    c_hold = C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy || done) seen++;
      @(negedge clk);
    end
    check("nomul_busy_done", seen, 0);
    check("nomul_c_held", C, c_hold);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
